// File: rtl/alu_multiciclo_if.sv
// Request/response bundle of the multicycle ALU.
// The master drives requests; the slave returns results.
interface alu_multiciclo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             inicio;
  logic [1:0]       aluOp;
  logic [5:0]       funct;
  logic [WIDTH-1:0] entrada0;
  logic [WIDTH-1:0] entrada1;
  logic             pronto;
  logic             valido;
  logic [WIDTH-1:0] saida;
  logic [WIDTH-1:0] saida_hi;
  logic             zero;
  logic             erro;

  modport master (
    output inicio, aluOp, funct, entrada0, entrada1,
    input  pronto, valido, saida, saida_hi, zero, erro
  );

  modport slave (
    input  inicio, aluOp, funct, entrada0, entrada1,
    output pronto, valido, saida, saida_hi, zero, erro
  );
endinterface

// File: rtl/alu_multiciclo.sv
// Multicycle ALU: single-cycle logic/arith ops, plus optional iterative multu/divu
// enabled by defining ALU_MULDIV_EN (shift-add multiply, restoring divide).
module alu_multiciclo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  alu_multiciclo_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_BNE   = 6'b000101;
  localparam logic [5:0] F_SLTI  = 6'b001010;
  localparam logic [5:0] F_ADDI  = 6'b001000;
`ifdef ALU_MULDIV_EN
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] a_c, b_c, sum_c, dif_c, res_c;
  logic             zero_c, erro_c, multi_c, last_c;

  logic [WIDTH-1:0] saida_q, saida_d, saida_hi_q, saida_hi_d;
  logic             zero_q, zero_d, erro_q, erro_d, valido_q, valido_d, pronto_q;

`ifdef ALU_MULDIV_EN
  logic             div_c;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, op_q, op_d;
  logic             div_q, div_d, div0_q, div0_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum_c, rs_c, df_c, rem_c;
  logic             ge_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;
`endif

  assign a_c   = bus.entrada0;
  assign b_c   = bus.entrada1;
  assign sum_c = a_c + b_c;
  assign dif_c = a_c - b_c;

  // Single-cycle decode and result; also flags the iterative ops
  always_comb begin
    res_c   = '0;
    zero_c  = 1'b0;
    erro_c  = 1'b0;
    multi_c = 1'b0;
`ifdef ALU_MULDIV_EN
    div_c   = 1'b0;
`endif
    case (bus.aluOp)
      2'b00: res_c = sum_c;
      2'b01: begin
        res_c  = dif_c;
        zero_c = (dif_c == '0);
      end
      2'b10: begin
        case (bus.funct)
          F_ADD:   res_c = sum_c;
          F_SUB:   res_c = dif_c;
          F_AND:   res_c = a_c & b_c;
          F_OR:    res_c = a_c | b_c;
          F_XOR:   res_c = a_c ^ b_c;
          F_NOR:   res_c = ~(a_c | b_c);
          F_SLT:   res_c = WIDTH'($signed(a_c) < $signed(b_c));
          F_SLTU:  res_c = WIDTH'(a_c < b_c);
`ifdef ALU_MULDIV_EN
          F_MULTU: multi_c = 1'b1;
          F_DIVU: begin
            multi_c = 1'b1;
            div_c   = 1'b1;
          end
`endif
          default: erro_c = 1'b1;
        endcase
      end
      2'b11: begin
        case (bus.funct)
          F_BNE:   zero_c = (a_c != b_c);
          F_SLTI:  res_c  = WIDTH'($signed(a_c) < $signed(b_c));
          F_ADDI:  res_c  = sum_c;
          default: erro_c = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  // One iteration: shift-add multiply step or restoring divide step
  always_comb begin
    mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_q} : '0);
    rs_c      = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge_c      = (rs_c >= {1'b0, op_q});
    df_c      = rs_c - {1'b0, op_q};
    rem_c     = ge_c ? df_c : rs_c;
    if (div_q) begin
      step_hi_c = WIDTH'(rem_c);
      step_lo_c = {acc_lo_q[WIDTH-2:0], ge_c};
    end else begin
      step_hi_c = mul_sum_c[WIDTH:1];
      step_lo_c = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  assign last_c = (cnt_q == CW'(WIDTH - 1));
`else
  assign last_c = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= OCIOSO;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      OCIOSO:  if (bus.inicio && multi_c) state_nxt = CALC;
      CALC:    if (last_c) state_nxt = FIM;
      FIM:     state_nxt = OCIOSO;
      default: state_nxt = OCIOSO;
    endcase
  end

  // Next values of the result registers and the iteration datapath
  always_comb begin
    saida_d    = saida_q;
    saida_hi_d = saida_hi_q;
    zero_d     = zero_q;
    erro_d     = erro_q;
    valido_d   = 1'b0;
`ifdef ALU_MULDIV_EN
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    op_d       = op_q;
    div_d      = div_q;
    div0_d     = div0_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (bus.inicio && !multi_c) begin
          saida_d    = res_c;
          saida_hi_d = '0;
          zero_d     = zero_c;
          erro_d     = erro_c;
          valido_d   = 1'b1;
        end
`ifdef ALU_MULDIV_EN
        if (bus.inicio && multi_c) begin
          acc_hi_d = '0;
          acc_lo_d = div_c ? a_c : b_c;
          op_d     = div_c ? b_c : a_c;
          div_d    = div_c;
          div0_d   = div_c && (b_c == '0);
          cnt_d    = '0;
        end
`endif
      end
      CALC: begin
`ifdef ALU_MULDIV_EN
        acc_hi_d = step_hi_c;
        acc_lo_d = step_lo_c;
        cnt_d    = cnt_q + CW'(1);
        if (last_c) begin
          saida_d    = step_lo_c;
          saida_hi_d = step_hi_c;
          zero_d     = 1'b0;
          erro_d     = div0_q;
          valido_d   = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      saida_q    <= '0;
      saida_hi_q <= '0;
      zero_q     <= 1'b0;
      erro_q     <= 1'b0;
      valido_q   <= 1'b0;
      pronto_q   <= 1'b1;
    end else begin
      saida_q    <= saida_d;
      saida_hi_q <= saida_hi_d;
      zero_q     <= zero_d;
      erro_q     <= erro_d;
      valido_q   <= valido_d;
      pronto_q   <= (state_nxt == OCIOSO);
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      op_q     <= '0;
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      op_q     <= op_d;
      div_q    <= div_d;
      div0_q   <= div0_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign bus.pronto   = pronto_q;
  assign bus.valido   = valido_q;
  assign bus.saida    = saida_q;
  assign bus.saida_hi = saida_hi_q;
  assign bus.zero     = zero_q;
  assign bus.erro     = erro_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: random and directed requests are checked
// against an arithmetic reference model; multu/divu coverage when ALU_MULDIV_EN is set.
module tb_alu_multiciclo;

  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  alu_multiciclo_if #(.WIDTH(W)) bus ();

  alu_multiciclo #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] h;
    logic         z;
    logic         e;
    int           vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: results from plain arithmetic; vcyc holds extra latency in cycles
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    longint unsigned pa, pb, p;
    r.s = '0; r.h = '0; r.z = 1'b0; r.e = 1'b0; r.vcyc = 0;
    pa = 64'(a); pb = 64'(b); p = 0;
    case (op)
      2'd0: r.s = a + b;
      2'd1: begin r.s = a - b; r.z = (a == b); end
      2'd2: case (fn)
        6'h20: r.s = a + b;
        6'h22: r.s = a - b;
        6'h24: r.s = a & b;
        6'h25: r.s = a | b;
        6'h26: r.s = a ^ b;
        6'h27: r.s = ~(a | b);
        6'h2a: r.s[0] = ($signed(a) < $signed(b));
        6'h2b: r.s[0] = (pa < pb);
`ifdef ALU_MULDIV_EN
        6'h19: begin
          p = pa * pb;
          r.s = p[W-1:0]; r.h = p[63:32]; r.vcyc = W;
        end
        6'h1b: begin
          r.vcyc = W;
          if (b == '0) begin r.s = '1; r.h = a; r.e = 1'b1; end
          else begin p = pa / pb; r.s = p[W-1:0]; p = pa % pb; r.h = p[W-1:0]; end
        end
`endif
        default: r.e = 1'b1;
      endcase
      default: case (fn)
        6'h05: r.z = (a != b);
        6'h0a: r.s[0] = ($signed(a) < $signed(b));
        6'h08: r.s = a + b;
        default: r.e = 1'b1;
      endcase
    endcase
    return r;
  endfunction

  // Monitor: every valido pulse must match the oldest outstanding request
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.valido === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_valido: got valido=1 expected no result (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("latency",  64'(cyc),      64'(mon_e.vcyc));
        chk("saida",    64'(bus.saida),    64'(mon_e.s));
        chk("saida_hi", 64'(bus.saida_hi), 64'(mon_e.h));
        chk("zero",     64'(bus.zero),     64'(mon_e.z));
        chk("erro",     64'(bus.erro),     64'(mon_e.e));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int guard = 0;
    while (bus.pronto !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (bus.pronto !== 1'b1) begin
      checks++; errors++;
      $display("FAIL pronto_timeout: got pronto=%b expected 1", bus.pronto);
      return;
    end
    bus.inicio = 1'b1; bus.aluOp = op; bus.funct = fn;
    bus.entrada0 = a; bus.entrada1 = b;
    e = model(op, fn, a, b);
    e.vcyc = cyc + 1 + e.vcyc;
    sb.push_back(e);
    @(negedge clock);
    bus.inicio = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return W'(32'h7FFF_FFFF);
      4: return W'(32'h8000_0000);
      5: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_pronto"},   64'(bus.pronto),   64'(1));
    chk({tag, "_valido"},   64'(bus.valido),   64'(0));
    chk({tag, "_saida"},    64'(bus.saida),    64'(0));
    chk({tag, "_saida_hi"}, 64'(bus.saida_hi), 64'(0));
    chk({tag, "_zero"},     64'(bus.zero),     64'(0));
    chk({tag, "_erro"},     64'(bus.erro),     64'(0));
  endtask

  logic [5:0] f10 [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h19, 6'h1b};
  logic [5:0] f11 [3]  = '{6'h05, 6'h0a, 6'h08};

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] a, b;
    int           guard;

    reset = 1'b1;
    bus.inicio = 1'b0; bus.aluOp = '0; bus.funct = '0;
    bus.entrada0 = '0; bus.entrada1 = '0;
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);

    // Back-to-back subtracts with zero flag
    issue(2'b01, 6'h00, 32'd5, 32'd5);
    issue(2'b01, 6'h00, 32'd7, 32'd5);
    // Signed/unsigned compare and wrapping add
    issue(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 6'h2b, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 6'h20, 32'h7FFF_FFFF, 32'd1);
    issue(2'b10, 6'h27, 32'h0F0F_0000, 32'h0000_00F0);
    issue(2'b11, 6'h05, 32'd3, 32'd4);
    issue(2'b11, 6'h05, 32'd4, 32'd4);
    issue(2'b11, 6'h0a, 32'h8000_0000, 32'd0);
    issue(2'b11, 6'h08, 32'hFFFF_FFFF, 32'd2);
    issue(2'b11, 6'h3f, 32'd1, 32'd2);
    issue(2'b10, 6'h3f, 32'd1, 32'd2);
    issue(2'b10, 6'h19, 32'd6, 32'd7);
    issue(2'b10, 6'h1b, 32'd100, 32'd7);
    issue(2'b10, 6'h1b, 32'd9, 32'd0);

`ifdef ALU_MULDIV_EN
    // Largest product, with inicio pulsed mid-calculation (must be ignored)
    issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clock);
    chk("pronto_in_calc", 64'(bus.pronto), 64'(0));
    bus.inicio = 1'b1; bus.aluOp = 2'b00; bus.entrada0 = 32'd1; bus.entrada1 = 32'd1;
    repeat (3) @(negedge clock);
    bus.inicio = 1'b0;

    // Reset ten cycles into a divide aborts it
    issue(2'b10, 6'h1b, 32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b0;
    check_reset_state("abort");
    repeat (W + 5) @(negedge clock);
`else
    issue(2'b10, 6'h1b, 32'd1000, 32'd3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_state("abort");
    @(negedge clock);
`endif

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 14))
        0:       begin op = 2'b00; fn = 6'($urandom); end
        1:       begin op = 2'b01; fn = 6'($urandom); end
        2, 3, 4, 5, 6, 7, 8:
                 begin op = 2'b10; fn = f10[$urandom_range(0, 7)]; end
        9:       begin op = 2'b10; fn = f10[$urandom_range(8, 9)]; end
        10, 11:  begin op = 2'b11; fn = f11[$urandom_range(0, 2)]; end
        12:      begin op = 2'b10; fn = 6'($urandom); end
        default: begin op = 2'b11; fn = 6'($urandom); end
      endcase
      a = rnd_opnd();
      b = ($urandom_range(0, 3) == 0) ? a : rnd_opnd();
      issue(op, fn, a, b);
      if ($urandom_range(0, 4) == 0) @(negedge clock);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d outstanding results expected 0", sb.size());
    end
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inicio  input  1  start request; accepted only when pronto=1.
REQ-005 SHALL have port aluOp  input  2  operation class.
REQ-006 SHALL have port funct  input  6  operation select within class 10/11.
REQ-007 SHALL have ports entrada0, entrada1  input  WIDTH  operands, sampled on the accepting edge.
REQ-008 SHALL have port pronto  output  1  idle and able to accept.
REQ-009 SHALL have port valido  output  1  one-cycle pulse: result outputs are valid.
REQ-010 SHALL have port saida  output  WIDTH  result (low product / quotient for mul/div).
REQ-011 SHALL have port saida_hi  output  WIDTH  high product / remainder; 0 for other ops.
REQ-012 SHALL have ports zero, erro  output  1 each  branch flag; invalid-op or divide-by-zero flag.

Function
REQ-013 SHALL implement states OCIOSO, CALC, FIM; pronto=1 only in OCIOSO.
REQ-014 SHALL accept on a posedge with inicio=1 in OCIOSO; inicio in any other state is ignored.
REQ-015 Single-cycle ops SHALL register results on the accepting edge, pulse valido for the next cycle, and stay in OCIOSO (back-to-back issue every cycle).
REQ-016 aluOp 00: add; aluOp 01: sub, zero=1 iff difference is 0.
REQ-017 aluOp 10 funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu (unsigned); slt/sltu results are 0 or 1 zero-extended.
REQ-018 aluOp 11 funct: 000101 bne (zero=1 iff operands differ, saida=0), 001010 slti (signed), 001000 addi.
REQ-019 All add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-020 zero SHALL be 0 for every op not named in REQ-016/018.
REQ-021 Unlisted aluOp/funct combinations SHALL complete in one cycle with saida=0, saida_hi=0, zero=0, erro=1.
REQ-022 Multi-cycle ops SHALL enter CALC on the accepting edge, iterate one bit per cycle for WIDTH cycles, go to FIM, assert valido for the FIM cycle, then return to OCIOSO; valido asserted WIDTH+1 cycles after acceptance.
REQ-023 Outputs SHALL hold their last value between valido pulses; erro is updated with each result.

Reset
REQ-024 reset=1 on a posedge SHALL force OCIOSO, saida=0, saida_hi=0, zero=0, erro=0, valido=0, iteration counter 0.
REQ-025 reset during CALC/FIM SHALL abort the operation with no valido pulse; reset has priority over inicio in the same cycle.

Configuration
REQ-026 With macro ALU_MULDIV_EN defined, aluOp 10 funct 011001 (multu: {saida_hi,saida} = unsigned 2*WIDTH product, shift-add) and 011011 (divu: saida=quotient, saida_hi=remainder, restoring) SHALL be multi-cycle per REQ-022.
REQ-027 divu with entrada1=0 SHALL still take WIDTH+1 cycles and return saida=all ones, saida_hi=entrada0, erro=1.
REQ-028 Without ALU_MULDIV_EN, funct 011001/011011 SHALL be handled as invalid per REQ-021, CALC/FIM are unreachable, and no multiplier/divider logic is synthesised.

Verification
REQ-029 WIDTH=32: aluOp=01, 5-5 -> next cycle valido=1, saida=0, zero=1; then 7-5 -> saida=2, zero=0.
REQ-030 aluOp=10 slt, entrada0=0xFFFFFFFF, entrada1=1 -> saida=1; sltu same operands -> saida=0; 0x7FFFFFFF+1 add -> saida=0x80000000.
REQ-031 ALU_MULDIV_EN, multu 0xFFFFFFFF*0xFFFFFFFF -> valido 33 cycles after accept, saida_hi=0xFFFFFFFE, saida=0x00000001; inicio pulsed mid-CALC ignored.
REQ-032 ALU_MULDIV_EN, divu 100/7 -> saida=14, saida_hi=2, erro=0; divu 9/0 -> saida=0xFFFFFFFF, saida_hi=9, erro=1.
REQ-033 reset asserted 10 cycles into divu -> next cycle pronto=1, all outputs 0, no valido ever pulsed for that op.
REQ-034 Macro undefined, multu requested -> one cycle later valido=1, saida=0, erro=1; aluOp=11 funct=111111 -> erro=1.
